l2todr_reqq: RTL and testbench
==============================

# l2todr_reqq

Directory-side ingress request queue between the L2 arbiter's `l2todr_req` output and the directory request pipeline. Buffers up to `Depth` L2-to-directory requests in order. Issues them downstream only while the number of in-flight (issued, not yet retired) requests is below `MaxInflight`, bounding directory occupancy. Payload is opaque (`I_l2todr_req_type`); no field is inspected or modified.

## Interface

Parameters:
- `Depth`, 4: FIFO entries; power of two, ≥2.
- `MaxInflight`, 8: max issued-but-unretired requests; ≥1, ≤255.

Ports:
- `clk`  in  1: clock; all state on rising edge.
- `reset`  in  1: synchronous, active-high.
- `l2todr_req_valid`  in  1: upstream request valid.
- `l2todr_req_retry`  out  1: upstream stall; transfer when valid && !retry.
- `l2todr_req`  in  `$bits(I_l2todr_req_type)`: upstream payload.
- `dr_req_valid`  out  1: request offered to directory.
- `dr_req_retry`  in  1: directory stall.
- `dr_req`  out  `$bits(I_l2todr_req_type)`: FIFO head payload.
- `dr_req_done`  in  1: one-cycle pulse, one previously issued request retired.
- `reqq_count`  out  `$clog2(Depth)+1`: FIFO occupancy.
- `inflight_count`  out  8: issued-unretired count.
- `err_underflow`  out  1: sticky; `dr_req_done` seen with `inflight_count`==0.

## Operation

- Enqueue: `l2todr_req_valid && !l2todr_req_retry` writes payload at tail, tail++ (mod `Depth`), count++.
- `l2todr_req_retry` = registered full (count==`Depth`) OR `reset`. Never depends combinationally on `l2todr_req_valid`.
- Issue gate: `dr_req_valid` = count≠0 AND `inflight_count` < `MaxInflight`.
- Dequeue: `dr_req_valid && !dr_req_retry` → head++, count--, `inflight_count`++.
- `dr_req` = head entry; stable while `dr_req_valid && dr_req_retry` (head moves only on dequeue; inflight only rises on dequeue, so valid cannot drop while stalled).
- Retire: `dr_req_done` → `inflight_count`--. Same-cycle dequeue and retire → unchanged.
- `dr_req_done` at 0 with no same-cycle dequeue: count stays 0, `err_underflow` set until reset. Same-cycle dequeue at 0: net 0, no error.
- Simultaneous enqueue/dequeue: count unchanged; only possible when not full (full ⇒ retry=1), and when non-empty.
- Order strictly FIFO; no reordering, bypass, or drop.

## Timing

- Reset (sync, `reset`=1 at edge): count=0, head=tail=0, `inflight_count`=0, `err_underflow`=0; outputs during and after reset: `dr_req_valid`=0, `reqq_count`=0, `inflight_count`=0, `err_underflow`=0; `l2todr_req_retry`=1 while `reset` high, 0 the first cycle after. `dr_req` don't-care while invalid.
- Reset mid-operation discards queued entries and in-flight count; no downstream valid the cycle after reset.
- Latency: request enqueued at edge N appears on `dr_req_valid` in cycle N+1 (no same-cycle bypass) if gate open.
- Full: retry asserts the cycle after the enqueue filling the last entry; deasserts the cycle after the first dequeue from full.
- Throughput: 1 req/cycle sustained when `dr_req_retry`=0 and retire rate keeps inflight < `MaxInflight`.
- Gate: retire at edge N reopens issue in cycle N+1.
- Pointer wrap: `Depth`-1 → 0; count never exceeds `Depth`.

## Test plan

- Reset, then 3 back-to-back requests A,B,C, `dr_req_retry`=0, done pulsed each issue → A,B,C out in cycles 1,2,3 after enqueue, in order; `inflight_count` stays ≤1.
- `dr_req_retry`=1 held, 5 requests offered (Depth=4) → 4 accepted, retry=1 from cycle after 4th, `reqq_count`=4; `dr_req` holds first payload; release retry → 4 issued in order, 5th accepted the cycle after first dequeue.
- MaxInflight=8, no done, 10 requests → exactly 8 issued, `dr_req_valid`=0 with count=2; one done pulse → 9th issued next cycle, `inflight_count` back to 8.
- Same-cycle dequeue + done at inflight=3 → `inflight_count` stays 3; done alone at 0 → `err_underflow`=1, remains 1 until reset.
- Stream of 20 requests with random `dr_req_retry` and done → output sequence equals input sequence; pointers wrap ≥4 times; no payload change while stalled.
- Reset asserted with 3 queued, inflight=5 → next cycle all counts 0, `dr_req_valid`=0, `err_underflow`=0, `l2todr_req_retry`=0.

Source files
------------

// File: rtl/l2todr_reqq_if.sv
// Request bus between the L2 arbiter, the directory ingress queue and the
// directory request pipeline.
//
// Handshake (both hops): the producer drives *_valid with a payload, and the
// consumer drives *_retry. A transfer happens on a rising edge where
// valid && !retry. A producer holding valid while retry is high must keep
// the payload stable until the transfer. retry never depends combinationally
// on valid.
interface l2todr_reqq_if #(
    parameter int W = 64
);
    logic         l2todr_req_valid;
    logic         l2todr_req_retry;
    logic [W-1:0] l2todr_req;
    logic         dr_req_valid;
    logic         dr_req_retry;
    logic [W-1:0] dr_req;
    logic         dr_req_done;

    // Environment side: L2 arbiter upstream plus the directory pipeline downstream.
    modport master (
        output l2todr_req_valid, l2todr_req, dr_req_retry, dr_req_done,
        input  l2todr_req_retry, dr_req_valid, dr_req
    );

    // Queue side.
    modport slave (
        input  l2todr_req_valid, l2todr_req, dr_req_retry, dr_req_done,
        output l2todr_req_retry, dr_req_valid, dr_req
    );
endinterface

// File: rtl/l2todr_reqq.sv
// Directory-side ingress request queue. An in-order FIFO of opaque L2-to-
// directory requests. The head is issued only while fewer than MaxInflight
// issued requests are still unretired. W is the bit width of the request
// type and is carried through untouched.
module l2todr_reqq #(
    parameter int Depth       = 4,
    parameter int MaxInflight = 8,
    parameter int W           = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    l2todr_reqq_if.slave           bus,
    output logic [$clog2(Depth):0] reqq_count,
    output logic [7:0]             inflight_count,
    output logic                   err_underflow
);
    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(Depth);
    localparam logic [7:0]  MAX_INF  = 8'(MaxInflight);

    logic [W-1:0]  r_mem [Depth];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_full;
    logic [7:0]    r_inflight;
    logic          r_err;

    logic          w_retry;
    logic          w_valid;
    logic          w_enq;
    logic          w_deq;
    logic [AW:0]   w_count_nxt;
    logic [7:0]    w_inflight_nxt;
    logic          w_underflow;

    // Upstream stall comes from a registered full flag, so it never loops back
    // through l2todr_req_valid. Reset forces a stall for its whole cycle.
    assign w_retry = r_full | reset;
    assign w_enq   = bus.l2todr_req_valid & ~w_retry;

    // Issue gate. inflight rises only on a dequeue, so once valid is up it
    // cannot drop while the directory stalls, and the head cannot move either.
    assign w_valid = ~reset & (r_count != '0) & (r_inflight < MAX_INF);
    assign w_deq   = w_valid & ~bus.dr_req_retry;

    assign bus.l2todr_req_retry = w_retry;
    assign bus.dr_req_valid     = w_valid;
    assign bus.dr_req           = r_mem[r_head];

    // Status is forced to its reset value while reset is high.
    assign reqq_count     = reset ? '0 : r_count;
    assign inflight_count = reset ? '0 : r_inflight;
    assign err_underflow  = reset ? 1'b0 : r_err;

    // Next occupancy: a simultaneous enqueue and dequeue cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_enq && !w_deq) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_enq && w_deq) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Next in-flight count. A retire with nothing outstanding and no same-cycle
    // issue leaves the count at zero and flags an underflow.
    always_comb begin
        w_inflight_nxt = r_inflight;
        w_underflow    = 1'b0;
        if (w_deq && !bus.dr_req_done) begin
            w_inflight_nxt = r_inflight + 1'b1;
        end else if (!w_deq && bus.dr_req_done) begin
            if (r_inflight == '0) begin
                w_underflow = 1'b1;
            end else begin
                w_inflight_nxt = r_inflight - 1'b1;
            end
        end
    end

    // Payload storage has no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= bus.l2todr_req;
        end
    end

    // Pointers, counters and the sticky error flag. Depth is a power of two,
    // so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == FULL_CNT);
            r_inflight <= w_inflight_nxt;
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_l2todr_reqq.sv
// Bench for l2todr_reqq (Depth=4, MaxInflight=8).
module tb_l2todr_reqq;
    localparam int W    = 16;
    localparam int CW   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l2todr_reqq_if #(.W(W)) bus();
    logic [CW-1:0] reqq_count;
    logic [7:0]    inflight_count;
    logic          err_underflow;

    l2todr_reqq #(.Depth(4), .MaxInflight(8), .W(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .reqq_count     (reqq_count),
        .inflight_count (inflight_count),
        .err_underflow  (err_underflow)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_popped = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!reset && prev_stall) begin
            check("stall_valid_hold", bus.dr_req_valid, 1);
            check("stall_payload_hold", bus.dr_req, prev_data);
        end
        if (bus.l2todr_req_valid && !bus.l2todr_req_retry)
            exp_q.push_back(bus.l2todr_req);
        if (bus.dr_req_valid && !bus.dr_req_retry) begin
            if (exp_q.size() == 0)
                check("deq_unexpected", 1, 0);
            else
                check("deq_order", bus.dr_req, exp_q.pop_front());
            n_popped++;
        end
        prev_stall = bus.dr_req_valid && bus.dr_req_retry;
        prev_data  = bus.dr_req;
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic rr, input logic dn);
        bus.l2todr_req_valid = v;
        bus.l2todr_req       = d;
        bus.dr_req_retry     = rr;
        bus.dr_req_done      = dn;
    endtask

    task automatic check_state(string tag, logic e_retry, logic e_val,
                               logic [CW-1:0] e_cnt, logic [7:0] e_inf, logic e_err);
        check({tag, "_retry"}, bus.l2todr_req_retry, e_retry);
        check({tag, "_valid"}, bus.dr_req_valid, e_val);
        check({tag, "_count"}, reqq_count, e_cnt);
        check({tag, "_inflight"}, inflight_count, e_inf);
        check({tag, "_err"}, err_underflow, e_err);
    endtask

    task automatic do_reset();
        drive(0, '0, 0, 0);
        reset = 1'b1;
        #1;
        check("in_reset_retry", bus.l2todr_req_retry, 1);
        check("in_reset_valid", bus.dr_req_valid, 0);
        check("in_reset_count", reqq_count, 0);
        check("in_reset_inflight", inflight_count, 0);
        cyc();
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_state("post_reset", 0, 0, 0, 0, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic          rr;
        logic          dn;
        logic          e_retry;
        logic          e_val;
        logic [CW-1:0] e_cnt;
        logic [7:0]    e_inf;
        logic          e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic [W-1:0] d, logic rr, logic dn,
                                logic er, logic ev, logic [CW-1:0] ec,
                                logic [7:0] ei, logic ee);
        vec_t r;
        r.v = v; r.d = d; r.rr = rr; r.dn = dn;
        r.e_retry = er; r.e_val = ev; r.e_cnt = ec; r.e_inf = ei; r.e_err = ee;
        tbl.push_back(r);
    endfunction

    initial begin
        int sent;
        int done_cnt;
        int base;
        int budget;
        logic v;
        logic rr;
        logic dn;

        drive(0, '0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        // Each row: inputs for one cycle, outputs expected after that edge.
        //   v  data      rr dn | retry val cnt inf err
        add(1, 16'hA00A, 0, 0,   0, 1, 1, 0, 0);  // A enq, visible next cycle
        add(1, 16'hB00B, 0, 0,   0, 1, 1, 1, 0);  // A out, B in
        add(1, 16'hC00C, 0, 1,   0, 1, 1, 1, 0);  // B out + retire A
        add(0, 16'h0000, 0, 1,   0, 0, 0, 1, 0);  // C out + retire B
        add(0, 16'h0000, 0, 1,   0, 0, 0, 0, 0);  // retire C
        add(1, 16'hD00D, 1, 0,   0, 1, 1, 0, 0);  // directory stalled, fill
        add(1, 16'hE00E, 1, 0,   0, 1, 2, 0, 0);
        add(1, 16'hF00F, 1, 0,   0, 1, 3, 0, 0);
        add(1, 16'h1001, 1, 0,   1, 1, 4, 0, 0);  // full -> retry next cycle
        add(1, 16'h2002, 1, 0,   1, 1, 4, 0, 0);  // 5th refused
        add(1, 16'h2002, 0, 0,   0, 1, 3, 1, 0);  // first dequeue from full
        add(1, 16'h2002, 0, 0,   0, 1, 3, 2, 0);  // 5th accepted
        add(0, 16'h0000, 0, 0,   0, 1, 2, 3, 0);
        add(0, 16'h0000, 0, 1,   0, 1, 1, 3, 0);  // dequeue + retire at 3
        add(0, 16'h0000, 0, 0,   0, 0, 0, 4, 0);
        add(0, 16'h0000, 0, 1,   0, 0, 0, 3, 0);
        add(0, 16'h0000, 0, 1,   0, 0, 0, 2, 0);
        add(0, 16'h0000, 0, 1,   0, 0, 0, 1, 0);
        add(0, 16'h0000, 0, 1,   0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 1,   0, 0, 0, 0, 1);  // retire at 0 -> error
        add(0, 16'h0000, 0, 0,   0, 0, 0, 0, 1);  // sticky
        add(1, 16'h3003, 0, 1,   0, 1, 1, 0, 1);
        add(0, 16'h0000, 0, 1,   0, 0, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].rr, tbl[i].dn);
            cyc();
            check_state($sformatf("vec%0d", i), tbl[i].e_retry, tbl[i].e_val,
                        tbl[i].e_cnt, tbl[i].e_inf, tbl[i].e_err);
        end
        drive(0, '0, 0, 0);
        cyc();

        // Same-cycle dequeue and retire at inflight 0: net zero, no error.
        do_reset();
        drive(1, 16'h4004, 0, 0);
        cyc();
        drive(0, '0, 0, 1);
        cyc();
        check_state("net_zero", 0, 0, 0, 0, 0);

        // Inflight cap: 10 requests and no retires -> 8 issued, 2 held.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, W'($urandom_range(0, 16'hFFFF)), 0, 0);
            cyc();
        end
        drive(0, '0, 0, 0);
        repeat (3) cyc();
        check_state("cap_hold", 0, 0, 2, 8, 0);
        drive(0, '0, 0, 1);
        cyc();
        drive(0, '0, 0, 0);
        check_state("cap_reopen", 0, 1, 2, 7, 0);
        cyc();
        check_state("cap_ninth", 0, 0, 1, 8, 0);

        // Random stream of 20 requests with random stalls and retires.
        do_reset();
        sent     = 0;
        done_cnt = 0;
        base     = n_popped;
        budget   = 0;
        while ((n_popped - base) < 20 && budget < 600) begin
            v  = (sent < 20) && ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) == 0);
            dn = ((n_popped - base - done_cnt) > 0) && ($urandom_range(0, 1) == 1);
            drive(v, W'($urandom_range(0, 16'hFFFF)), rr, dn);
            if (v && !bus.l2todr_req_retry) sent++;
            if (dn) done_cnt++;
            cyc();
            budget++;
        end
        drive(0, '0, 0, 0);
        cyc();
        check("stream_issued", n_popped - base, 20);
        check("stream_q_empty", exp_q.size(), 0);
        check("stream_inflight", inflight_count, 20 - done_cnt);
        check("stream_err", err_underflow, 0);

        // Reset with 3 queued and 5 in flight.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, W'($urandom_range(0, 16'hFFFF)), 0, 0);
            cyc();
        end
        drive(0, '0, 0, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1, W'($urandom_range(0, 16'hFFFF)), 1, 0);
            cyc();
        end
        drive(0, '0, 1, 0);
        cyc();
        check_state("pre_midreset", 0, 1, 3, 5, 0);
        do_reset();
        cyc();
        check_state("after_midreset", 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
